// File: rtl/uart_pkg.sv
// uart_pkg: shared constants and types for the UART receive path.
//   UART_DATA_W                      - receiver byte width
//   UART_RX_FIFO_DEPTH_LOG2_DEFAULT  - default log2 depth of the receive FIFO
//   uart_byte_t                      - one received byte
package uart_pkg;

    localparam int unsigned UART_DATA_W = 8;
    localparam int unsigned UART_RX_FIFO_DEPTH_LOG2_DEFAULT = 3;

    typedef logic [UART_DATA_W-1:0] uart_byte_t;

endpackage

// File: rtl/uart_rx_fifo_mem.sv
// uart_rx_fifo_mem: DEPTH x DATA_W register array backing the receive FIFO.
// Ports:
//   CLK_BPS - bit-rate clock, write on posedge
//   we      - write enable
//   waddr   - write address
//   wdata   - write data
//   raddr   - read address
//   rdata   - asynchronous read data (mem[raddr])
// Contents are not reset; the FIFO control logic tracks which entries are live.
module uart_rx_fifo_mem
    import uart_pkg::*;
#(
    parameter int unsigned DATA_W     = UART_DATA_W,
    parameter int unsigned DEPTH_LOG2 = UART_RX_FIFO_DEPTH_LOG2_DEFAULT
) (
    input  logic                  CLK_BPS,
    input  logic                  we,
    input  logic [DEPTH_LOG2-1:0] waddr,
    input  logic [DATA_W-1:0]     wdata,
    input  logic [DEPTH_LOG2-1:0] raddr,
    output logic [DATA_W-1:0]     rdata
);

    localparam int unsigned DEPTH = 1 << DEPTH_LOG2;

    logic [DATA_W-1:0] mem [DEPTH];

    always_ff @(posedge CLK_BPS) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/uart_rx_fifo.sv
// uart_rx_fifo: receive-side byte buffer behind the UART receiver.
// Each 0->1 transition of accept pushes receive_data into a 2**DEPTH_LOG2 entry
// circular FIFO; the host pops through rd_en/rd_valid.
// Ports:
//   CLK_BPS        - bit-rate clock shared with the receiver
//   reset          - synchronous active-high reset
//   receive_data   - received byte, stable while accept=1
//   accept         - receiver frame-done level
//   rd_en          - host pop request
//   rd_data        - popped byte
//   rd_valid       - rd_data holds a valid byte
//   empty / full   - status derived from the registered level
//   level          - entry count 0..DEPTH
//   overflow       - sticky: a byte was dropped while full
//   clear_overflow - clears overflow (a simultaneous drop wins)
// Build option: define UART_RX_FIFO_FWFT_EN for first-word-fall-through reads
// (rd_data shows the head combinationally, rd_valid = ~empty, rd_en acknowledges).
// Otherwise reads are registered: rd_valid pulses the cycle after each pop.
// DEPTH_LOG2 must be within 1..6.
module uart_rx_fifo
    import uart_pkg::*;
#(
    parameter int unsigned DATA_W     = UART_DATA_W,
    parameter int unsigned DEPTH_LOG2 = UART_RX_FIFO_DEPTH_LOG2_DEFAULT
) (
    input  logic                  CLK_BPS,
    input  logic                  reset,
    input  logic [DATA_W-1:0]     receive_data,
    input  logic                  accept,
    input  logic                  rd_en,
    output logic [DATA_W-1:0]     rd_data,
    output logic                  rd_valid,
    output logic                  empty,
    output logic                  full,
    output logic [DEPTH_LOG2:0]   level,
    output logic                  overflow,
    input  logic                  clear_overflow
);

    localparam logic [DEPTH_LOG2:0] LEVEL_FULL = {1'b1, {DEPTH_LOG2{1'b0}}};

    logic                  accept_d;
    logic [DEPTH_LOG2-1:0] wr_ptr_q;
    logic [DEPTH_LOG2-1:0] rd_ptr_q;
    logic [DEPTH_LOG2:0]   level_q;
    logic                  overflow_q;
    logic [DATA_W-1:0]     mem_rdata;

    logic push;
    logic pop;
    logic push_ok;
    logic drop;

    always_comb begin
        push    = accept & ~accept_d;
        pop     = rd_en & ~empty;
        // A pop on the same edge frees the slot, so a push at full still lands.
        push_ok = push & (~full | pop);
        drop    = push & full & ~pop;
    end

    always_ff @(posedge CLK_BPS) begin
        if (reset) begin
            accept_d   <= 1'b0;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            level_q    <= '0;
            overflow_q <= 1'b0;
        end else begin
            accept_d <= accept;
            if (push_ok) begin
                wr_ptr_q <= wr_ptr_q + DEPTH_LOG2'(1);
            end
            if (pop) begin
                rd_ptr_q <= rd_ptr_q + DEPTH_LOG2'(1);
            end
            if (push_ok && !pop) begin
                level_q <= level_q + (DEPTH_LOG2 + 1)'(1);
            end else if (pop && !push_ok) begin
                level_q <= level_q - (DEPTH_LOG2 + 1)'(1);
            end
            // Set has priority over clear.
            if (drop) begin
                overflow_q <= 1'b1;
            end else if (clear_overflow) begin
                overflow_q <= 1'b0;
            end
        end
    end

    uart_rx_fifo_mem #(
        .DATA_W     (DATA_W),
        .DEPTH_LOG2 (DEPTH_LOG2)
    ) u_mem (
        .CLK_BPS (CLK_BPS),
        .we      (push_ok),
        .waddr   (wr_ptr_q),
        .wdata   (receive_data),
        .raddr   (rd_ptr_q),
        .rdata   (mem_rdata)
    );

    assign empty    = (level_q == '0);
    assign full     = (level_q == LEVEL_FULL);
    assign level    = level_q;
    assign overflow = overflow_q;

`ifdef UART_RX_FIFO_FWFT_EN
    // Mask the stale array word so rd_data reads 0 whenever nothing is stored.
    assign rd_data  = empty ? '0 : mem_rdata;
    assign rd_valid = ~empty;
`else
    logic [DATA_W-1:0] rd_data_q;
    logic              rd_valid_q;

    always_ff @(posedge CLK_BPS) begin
        if (reset) begin
            rd_data_q  <= '0;
            rd_valid_q <= 1'b0;
        end else begin
            rd_valid_q <= pop;
            if (pop) begin
                rd_data_q <= mem_rdata;
            end
        end
    end

    assign rd_data  = rd_data_q;
    assign rd_valid = rd_valid_q;
`endif

endmodule
